// File: rtl/mc_control.sv
// mc_control: multicycle MIPS control FSM with run gating and debug state.
//   clk, rst (async, active-high), run (issue enable sampled in FETCH)
//   opcode, func (IR fields), zero (ALU zero flag, gates PCEn in BRANCH)
//   PCEn..ALUSel: Moore datapath strobes decoded from the current state
//   state (current encoding), illegal (sticky), retired (instruction count)
module mc_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    output logic             PCEn,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [2:0]       ALUSel,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_RTEX   = 4'd6;
    localparam logic [3:0] S_RTWB   = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_IEX    = 4'd10;
    localparam logic [3:0] S_IWB    = 4'd11;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    logic [3:0]       state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q;
    logic [2:0]       rt_alu;
    logic             funct_ok;
    logic             retire;
    always_comb begin
        funct_ok = 1'b1;
        rt_alu   = ALU_ADD;
        case (func)
            6'h20:   rt_alu = ALU_ADD;
            6'h22:   rt_alu = ALU_SUB;
            6'h24:   rt_alu = 3'b000;
            6'h25:   rt_alu = 3'b001;
            6'h2A:   rt_alu = 3'b111;
            default: funct_ok = 1'b0;
        endcase
    end
    // Every terminal state falls back to FETCH, so it retires on its exit edge.
    assign retire = state_q inside {S_MEMWB, S_MEMWR, S_RTWB, S_IWB, S_BRANCH, S_JUMP};
    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:  state_d = run ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    6'h23, 6'h2B: state_d = S_MEMADR;
                    6'h00:        state_d = S_RTEX;
                    6'h04, 6'h05: state_d = S_BRANCH;
                    6'h02:        state_d = S_JUMP;
                    6'h08:        state_d = S_IEX;
                    default:      illegal_d = 1'b1;
                endcase
            end
            S_MEMADR: state_d = (opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_RTEX: begin
                state_d   = funct_ok ? S_RTWB : S_FETCH;
                illegal_d = illegal_q | ~funct_ok;
            end
            S_IEX:    state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_q + {{(CNT_W-1){1'b0}}, retire};
        end
    end
    // Strobes are gated by rst so an aborted instruction cannot write anything.
    always_comb begin
        PCEn = 1'b0; IorD = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        MemtoReg = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0; RegDst = 1'b0;
        ALUSrcA = 1'b0; ALUSrcB = 2'd0; PCSource = 2'd0; ALUSel = 3'b000;
        if (!rst) begin
            case (state_q)
                S_FETCH: if (run) begin
                    MemRead = 1'b1; IRWrite = 1'b1; ALUSrcB = 2'd1;
                    ALUSel = ALU_ADD; PCEn = 1'b1;
                end
                S_DECODE: begin ALUSrcB = 2'd2; ALUSel = ALU_ADD; end
                S_MEMADR, S_IEX: begin ALUSrcA = 1'b1; ALUSrcB = 2'd2; ALUSel = ALU_ADD; end
                S_MEMRD: begin IorD = 1'b1; MemRead = 1'b1; end
                S_MEMWB: begin RegWrite = 1'b1; MemtoReg = 1'b1; end
                S_MEMWR: begin IorD = 1'b1; MemWrite = 1'b1; end
                S_RTEX:  begin ALUSrcA = 1'b1; ALUSel = rt_alu; end
                S_RTWB:  begin RegWrite = 1'b1; RegDst = 1'b1; end
                S_BRANCH: begin
                    ALUSrcA = 1'b1; ALUSel = ALU_SUB; PCSource = 2'd1;
                    PCEn = (opcode == 6'h05) ? ~zero : zero;
                end
                S_JUMP:  begin PCSource = 2'd2; PCEn = 1'b1; end
                S_IWB:   RegWrite = 1'b1;
                default: ;
            endcase
        end
    end
    assign state   = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized self-checking bench for mc_control against a path/table model.
module tb_mc_control;
    logic clk = 1'b0, rst = 1'b1, run = 1'b0, zero = 1'b0;
    logic [5:0] opcode = '0, func = '0;
    logic PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUSel;
    logic [3:0] state;
    logic illegal;
    logic [3:0] retired;
    logic [15:0] ctl;
    int tests = 0, fails = 0;
    int m_ret = 0;
    bit m_ill = 0;
    mc_control #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .func(func), .zero(zero),
        .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUSel(ALUSel),
        .state(state), .illegal(illegal), .retired(retired)
    );
    always #5 clk = ~clk;
    assign ctl = {PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst,
                  ALUSrcA, ALUSrcB, PCSource, ALUSel};
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic bit fn_ok(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    endfunction
    function automatic logic [2:0] fn_alu(input logic [5:0] fn);
        if (fn == 6'h22) return 3'b110;
        if (fn == 6'h24) return 3'b000;
        if (fn == 6'h25) return 3'b001;
        if (fn == 6'h2A) return 3'b111;
        return 3'b010;
    endfunction
    // Expected strobes for a named state, straight from the per-state output table.
    function automatic logic [15:0] exp_ctl(input int s, input logic r, input logic z,
                                            input logic [5:0] op, input logic [5:0] fn);
        logic pcen, iord, mr, mw, m2r, irw, rw, rd, sa;
        logic [1:0] sb, ps;
        logic [2:0] alu;
        {pcen, iord, mr, mw, m2r, irw, rw, rd, sa, sb, ps, alu} = '0;
        case (s)
            0: if (r) begin mr = 1; irw = 1; sb = 1; alu = 3'b010; pcen = 1; end
            1: begin sb = 2; alu = 3'b010; end
            2, 10: begin sa = 1; sb = 2; alu = 3'b010; end
            3: begin iord = 1; mr = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin iord = 1; mw = 1; end
            6: begin sa = 1; alu = fn_alu(fn); end
            7: begin rw = 1; rd = 1; end
            8: begin sa = 1; alu = 3'b110; ps = 1; pcen = (op == 6'h05) ? !z : z; end
            9: begin ps = 2; pcen = 1; end
            11: rw = 1;
            default: ;
        endcase
        return {pcen, iord, mr, mw, m2r, irw, rw, rd, sa, sb, ps, alu};
    endfunction
    // Runs one instruction from FETCH; zsel<0 randomizes zero every cycle.
    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int zsel);
        int path[$];
        bit bad = 0;
        opcode = op; func = fn; run = 1;
        zero = (zsel < 0) ? 1'($urandom) : 1'(zsel);
        if (op == 6'h23) path = {0, 1, 2, 3, 4};
        else if (op == 6'h2B) path = {0, 1, 2, 5};
        else if (op == 6'h00) begin
            bad = !fn_ok(fn);
            path = bad ? {0, 1, 6} : {0, 1, 6, 7};
        end
        else if (op == 6'h04 || op == 6'h05) path = {0, 1, 8};
        else if (op == 6'h02) path = {0, 1, 9};
        else if (op == 6'h08) path = {0, 1, 10, 11};
        else begin bad = 1; path = {0, 1}; end
        for (int i = 0; i < path.size(); i++) begin
            @(negedge clk);
            check($sformatf("state op%0h step%0d", op, i), state, path[i]);
            check($sformatf("ctl op%0h st%0d", op, path[i]), ctl, exp_ctl(path[i], run, zero, op, fn));
            @(posedge clk); #1;
            zero = (zsel < 0) ? 1'($urandom) : 1'(zsel);
            run = 1'($urandom);
        end
        if (bad) m_ill = 1; else m_ret++;
        check("end_state", state, 0);
        check("retired", retired, m_ret % 16);
        check("illegal", illegal, m_ill);
    endtask
    initial begin
        logic [5:0] ops [7] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h02, 6'h08};
        logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        #2;
        check("rst_state", state, 0);
        check("rst_ctl", ctl, 0);
        check("rst_retired", retired, 0);
        check("rst_illegal", illegal, 0);
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_state", state, 0);
            check("hold_ctl", ctl, 0);
        end
        @(posedge clk); #1;
        do_instr(6'h23, 6'h00, -1);
        foreach (fns[i]) do_instr(6'h00, fns[i], -1);
        do_instr(6'h00, 6'h21, -1);
        do_instr(6'h04, 6'h00, 1);
        do_instr(6'h04, 6'h00, 0);
        do_instr(6'h05, 6'h00, 1);
        do_instr(6'h05, 6'h00, 0);
        do_instr(6'h02, 6'h00, -1);
        do_instr(6'h3F, 6'h00, -1);
        do_instr(6'h08, 6'h00, -1);
        do_instr(6'h2B, 6'h00, -1);
        opcode = 6'h00; func = 6'h20; run = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_rtex", state, 6);
        #2 rst = 1;
        #1;
        check("arst_state", state, 0);
        check("arst_ctl", ctl, 0);
        check("arst_retired", retired, 0);
        check("arst_illegal", illegal, 0);
        #3 rst = 0;
        #1;
        check("post_rst_fetch", ctl, exp_ctl(0, 1, zero, opcode, func));
        run = 0;
        m_ret = 0; m_ill = 0;
        @(posedge clk); #1;
        check("post_rst_hold", state, 0);
        for (int i = 0; i < 16; i++) do_instr(6'h02, 6'h00, -1);
        check("wrap", retired, 0);
        for (int n = 0; n < 300; n++) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            do_instr(op, fn, -1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
